// File: rtl/seq_pkg.sv
// Shared constants and helpers for the input conditioning stage.
// Holds the default qualification length and the counter width helper.
package seq_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 4;

    // ceil(log2(n)), but never narrower than one bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit flop synchronizer, all stages reset to 0.
// STAGES must be 2 or more; the last stage is the only safe output.
import seq_pkg::*;

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // shift the raw input through the metastability chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronize, debounce and edge-detect one raw input bit.
// Define DEBOUNCE_SYNC3_EN for a three-stage synchronizer.
import seq_pkg::*;

module debounce_edge #(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = clog2_min1(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef DEBOUNCE_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    logic             w_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_sync)
    );

    // qualify a level change for STABLE_CYCLES clocks, then commit and pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sync == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt < CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_q    <= w_sync;
                r_cnt  <= '0;
                r_rise <= w_sync;
                r_fall <= ~w_sync;
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (w_sync != r_q);

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge, STABLE_CYCLES=4, two-stage sync.
// Each vector: {rst, din} applied before an edge, {q,rise,fall,busy} after it.
module tb_debounce_edge;

    logic clk;
    logic rst;
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_checks;
    int n_fail;

    typedef struct {
        int         idx;
        logic [3:0] exp;
    } sb_t;

    sb_t sb_q [$];

    logic [5:0] vec [$];

    debounce_edge #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vector format: {rst, din, q, rise, fall, busy}
    initial begin
        vec = '{
            // reset with din high, then rise after full latency
            6'b11_0000, 6'b11_0000,
            6'b01_0000, 6'b01_0001, 6'b01_0001, 6'b01_0001,
            6'b01_0001, 6'b01_1100, 6'b01_1000, 6'b01_1000,
            // clean falling step
            6'b00_1000, 6'b00_1001, 6'b00_1001, 6'b00_1001,
            6'b00_1001, 6'b00_0010, 6'b00_0000, 6'b00_0000,
            // bounce 1,0,1,0 then hold 1
            6'b01_0000, 6'b00_0001, 6'b01_0000, 6'b00_0001,
            6'b01_0000, 6'b01_0001, 6'b01_0001, 6'b01_0001,
            6'b01_0001, 6'b01_1100, 6'b01_1000,
            // back to 0
            6'b00_1000, 6'b00_1001, 6'b00_1001, 6'b00_1001,
            6'b00_1001, 6'b00_0010, 6'b00_0000,
            // three-sample glitch
            6'b01_0000, 6'b01_0001, 6'b01_0001, 6'b00_0001,
            6'b00_0000, 6'b00_0000, 6'b00_0000,
            // reset while cnt==2, din held high
            6'b01_0000, 6'b01_0001, 6'b01_0001, 6'b01_0001,
            6'b11_0000, 6'b01_0000, 6'b01_0001, 6'b01_0001,
            6'b01_0001, 6'b01_0001, 6'b01_1100, 6'b01_1000
        };
    end

    // stimulus: drive inputs, and after the edge queue the expected outputs
    initial begin
        sb_t e;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        din      = 1'b1;
        #1;
        for (int i = 0; i < vec.size(); i++) begin
            rst = vec[i][5];
            din = vec[i][4];
            @(posedge clk);
            e.idx = i;
            e.exp = vec[i][3:0];
            sb_q.push_back(e);
            #1;
        end
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            @(posedge clk);
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0",
                     sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // monitor: outputs are stable mid-cycle; pop and compare
    initial begin
        sb_t        e;
        logic [3:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e   = sb_q.pop_front();
                act = {q, rise, fall, busy};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL vec%0d: q/rise/fall/busy got %b expected %b",
                             e.idx, act, e.exp);
                end
                n_checks++;
                if ((rise === 1'b1) && (fall === 1'b1)) begin
                    n_fail++;
                    $display("FAIL excl%0d: rise=%b fall=%b expected not both 1",
                             e.idx, rise, fall);
                end
            end
        end
    end

endmodule
